// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state codes, opcode constants, ALU-op codes and instruction classes
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ILL    = 3'd0,
        CL_R      = 3'd1,
        CL_I      = 3'd2,
        CL_LOAD   = 3'd3,
        CL_STORE  = 3'd4,
        CL_BRANCH = 3'd5,
        CL_MUL    = 3'd6
    } class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MUL    = 7'b0000001;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_RTYPE  = 2'd1;
    localparam logic [1:0] ALU_BRANCH = 2'd2;
    localparam logic [1:0] ALU_MUL    = 2'd3;

    // MUL falls back to the R-type code when the multiplier is not built in
    function automatic logic [1:0] alu_code(input class_t c, input logic mul_en);
        return (c == CL_BRANCH) ? ALU_BRANCH :
               (c == CL_MUL)    ? (mul_en ? ALU_MUL : ALU_RTYPE) :
               (c == CL_R)      ? ALU_RTYPE : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: IR/memory handshake inputs and datapath control outputs of the control unit
interface multicycle_control_if #(
    parameter int ALUOP_W = 2
);
    logic               start_i;
    logic [6:0]         opcode_i;
    logic [6:0]         funct7_i;
    logic               mem_ready_i;
    logic               pc_write_o;
    logic               ir_write_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               alu_src_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic               branch_o;
    logic               mem_to_reg_o;
    logic               reg_write_o;
    logic               illegal_o;
    logic               retire_o;
    logic [2:0]         state_o;

    modport master (
        output start_i, opcode_i, funct7_i, mem_ready_i,
        input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o,
               branch_o, mem_to_reg_o, reg_write_o, illegal_o, retire_o, state_o
    );

    modport slave (
        input  start_i, opcode_i, funct7_i, mem_ready_i,
        output pc_write_o, ir_write_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o,
               branch_o, mem_to_reg_o, reg_write_o, illegal_o, retire_o, state_o
    );
endinterface

// File: rtl/multicycle_control_opcode_classify.sv
// opcode_classify: maps opcode/funct7 to an instruction class and flags unsupported opcodes
module opcode_classify
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    output class_t     cls,
    output logic       illegal
);

    // MUL is always reported; the top decides whether it executes as MUL or plain R-type
    always_comb begin
        cls = CL_ILL;
        case (opcode)
            OP_R:      cls = (funct7 == F7_MUL) ? CL_MUL : CL_R;
            OP_I:      cls = CL_I;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            default:   cls = CL_ILL;
        endcase
        illegal = (cls == CL_ILL);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset; MUL execute enabled by MULTICYCLE_CONTROL_MUL_EN
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int MUL_LATENCY = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    multicycle_control_if.slave bus
);

    if (ALUOP_W < 2 || MUL_LATENCY < 1 || MUL_LATENCY > 16) begin : g_bad_param
        $error("multicycle_control: ALUOP_W must be >= 2 and MUL_LATENCY within 1..16");
    end

    state_t state;
    class_t op_q;
    class_t cls;
    state_t bnd;
    logic   illegal;
    logic   mul_en;

`ifdef MULTICYCLE_CONTROL_MUL_EN
    logic [3:0] mul_cnt;
    assign mul_en = 1'b1;
`else
    assign mul_en = 1'b0;
`endif

    opcode_classify u_classify (
        .opcode  (bus.opcode_i),
        .funct7  (bus.funct7_i),
        .cls     (cls),
        .illegal (illegal)
    );

    assign bnd = bus.start_i ? S_FETCH : S_IDLE;

    // State sequencing, class latch in DECODE and MUL cycle counter in EXEC
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            op_q  <= CL_ILL;
`ifdef MULTICYCLE_CONTROL_MUL_EN
            mul_cnt <= 4'd0;
`endif
        end else begin
            case (state)
                S_IDLE:   if (bus.start_i) state <= S_FETCH;
                S_FETCH:  if (bus.mem_ready_i) state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= cls;
                    state <= illegal ? bnd : S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == CL_BRANCH) state <= bnd;
                    else if (op_q == CL_LOAD || op_q == CL_STORE) state <= S_MEM;
`ifdef MULTICYCLE_CONTROL_MUL_EN
                    else if (op_q == CL_MUL && mul_cnt != 4'(MUL_LATENCY - 1)) mul_cnt <= mul_cnt + 4'd1;
                    else begin
                        mul_cnt <= 4'd0;
                        state   <= S_WB;
                    end
`else
                    else state <= S_WB;
`endif
                end
                S_MEM:    if (bus.mem_ready_i) state <= (op_q == CL_LOAD) ? S_WB : bnd;
                S_WB:     state <= bnd;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Per-state datapath enables; everything reads 0 while reset is held
    always_comb begin
        bus.pc_write_o   = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.mem_read_o   = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.alu_src_o    = 1'b0;
        bus.alu_op_o     = '0;
        bus.branch_o     = 1'b0;
        bus.mem_to_reg_o = 1'b0;
        bus.reg_write_o  = 1'b0;
        bus.illegal_o    = 1'b0;
        bus.retire_o     = 1'b0;
        bus.state_o      = rst_i ? 3'd0 : state;
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    bus.mem_read_o = 1'b1;
                    bus.ir_write_o = bus.mem_ready_i;
                    bus.pc_write_o = bus.mem_ready_i;
                end
                S_DECODE: bus.illegal_o = illegal;
                S_EXEC: begin
                    bus.alu_src_o = (op_q == CL_I || op_q == CL_LOAD || op_q == CL_STORE);
                    bus.alu_op_o  = ALUOP_W'(alu_code(op_q, mul_en));
                    bus.branch_o  = (op_q == CL_BRANCH);
                    bus.retire_o  = (op_q == CL_BRANCH);
                end
                S_MEM: begin
                    bus.mem_read_o  = (op_q == CL_LOAD);
                    bus.mem_write_o = (op_q == CL_STORE);
                    bus.retire_o    = (op_q == CL_STORE) && bus.mem_ready_i;
                end
                S_WB: begin
                    bus.reg_write_o  = 1'b1;
                    bus.mem_to_reg_o = (op_q == CL_LOAD);
                    bus.retire_o     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32 subset CPU: next generation of the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction/data memory, and drives per-state datapath enables. It adds load, store and branch classes, plus an optional multi-cycle MUL execute. It sits between the instruction register and the datapath muxes, register file, ALU and PC.

## Interface
- `ALUOP_W`, 2: width of `alu_op_o`; legal values ≥ 2; codes zero-extended.
- `MUL_LATENCY`, 4: EXEC cycles for MUL; legal range 1..16.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: run enable; sampled in IDLE and at instruction boundaries.
- `opcode_i` in 7: instruction[6:0] from IR; sampled in DECODE.
- `funct7_i` in 7: instruction[31:25] from IR; sampled in DECODE.
- `mem_ready_i` in 1: memory completes current access this cycle.
- `pc_write_o` out 1: PC update enable.
- `ir_write_o` out 1: IR load enable.
- `mem_read_o` out 1: memory read request.
- `mem_write_o` out 1: memory write request.
- `alu_src_o` out 1: 1 = immediate, 0 = rs2.
- `alu_op_o` out ALUOP_W: 0 = add, 1 = R-type funct, 2 = branch compare, 3 = mul.
- `branch_o` out 1: conditional PC update; datapath qualifies with ALU zero.
- `mem_to_reg_o` out 1: write-back source is memory.
- `reg_write_o` out 1: register file write enable.
- `illegal_o` out 1: unsupported opcode pulse.
- `retire_o` out 1: one-cycle pulse on instruction completion.
- `state_o` out 3: current state code.

## Operation
- State codes: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5.
- Classes:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - MUL = R with funct7 0000001
  - anything else is illegal.
- IDLE: all outputs 0. Go to FETCH when `start_i` = 1.
- FETCH: `mem_read_o` = 1. `ir_write_o` = `pc_write_o` = `mem_ready_i` (combinational). Advance to DECODE on `mem_ready_i`; otherwise hold.
- DECODE: latch class into `op_q`.
  - Legal opcode: go to EXEC.
  - Illegal opcode: `illegal_o` = 1 and `retire_o` = 0 this cycle, then go to the boundary (see Boundary).
- EXEC, by class:
  - I, LOAD, STORE: `alu_src_o` = 1, `alu_op_o` = 0.
  - R: `alu_src_o` = 0, `alu_op_o` = 1.
  - BRANCH: `alu_src_o` = 0, `alu_op_o` = 2, `branch_o` = 1, `retire_o` = 1, then boundary.
  - LOAD and STORE go to MEM; R, I and MUL go to WB.
- MEM:
  - LOAD: `mem_read_o` = 1.
  - STORE: `mem_write_o` = 1.
  - Hold until `mem_ready_i`. Then LOAD goes to WB; STORE asserts `retire_o` = 1 and goes to boundary.
- WB: `reg_write_o` = 1, `mem_to_reg_o` = 1 if LOAD, `retire_o` = 1, then boundary.
- Boundary: go to FETCH if `start_i` = 1, else IDLE. An instruction in flight always completes regardless of `start_i`.
- Outputs not listed for a state are 0.

## Timing
- Reset: while `rst_i` = 1, every output is forced to 0 combinationally; `state_o` reads 0. Next edge: state = IDLE, `op_q` = 0, MUL counter = 0. Reset mid-instruction abandons it with no retire.
- Latency from FETCH entry, with `mem_ready_i` tied to 1:
  - BRANCH: 3 cycles.
  - R, I, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - MUL: 3 + MUL_LATENCY cycles.
- Each wait cycle on `mem_ready_i` adds 1 cycle.
- MUL: counter runs 0..MUL_LATENCY-1 in EXEC, leaves on the last count, and clears on exit.
- `mem_ready_i` is ignored outside FETCH and MEM.

## Configuration
- `MULTICYCLE_CONTROL_MUL_EN` defined:
  - funct7 0000001 with opcode R selects MUL.
  - EXEC lasts MUL_LATENCY cycles with `alu_op_o` = 3 throughout.
- Not defined:
  - No counter logic.
  - MUL encodings execute as plain R-type: 1 EXEC cycle, `alu_op_o` = 1.

## Structure
- `multicycle_control_pkg` holds:
  - state enum and its codes;
  - opcode constants;
  - ALU-op codes;
  - class enum.
- One sub-module, `opcode_classify`: combinational opcode/funct7 to class + illegal flag.
- Top level holds the state register, `op_q`, MUL counter and output decode.

## Test plan
- Reset mid-LOAD (in MEM), `rst_i` = 1 for 1 cycle -> all outputs 0 during reset; `state_o` = 0 after the edge; no `retire_o`.
- R-type 0110011, `mem_ready_i` = 1 -> states 1,2,3,5; `reg_write_o` = 1 in cycle 4 only; `retire_o` pulses in cycle 4.
- LOAD with `mem_ready_i` held 0 for 2 cycles in FETCH and 3 cycles in MEM -> 10 cycles total; `mem_to_reg_o` = 1 in WB; `ir_write_o` pulses exactly once.
- STORE then BRANCH back-to-back -> `mem_write_o` only in MEM; `branch_o` = 1 with `alu_op_o` = 2 in branch EXEC; no `reg_write_o`.
- Opcode 1111111 -> `illegal_o` = 1 in DECODE; next state FETCH; no write, no retire.
- MUL with macro defined, MUL_LATENCY = 4 -> EXEC holds 4 cycles with `alu_op_o` = 3. Without macro: 1 cycle, `alu_op_o` = 1. `start_i` dropped during EXEC -> instruction completes, then IDLE.
